// File: rtl/riscv_v_pkg.sv
// Shared types and opcode constants for the vector dispatch path.
package riscv_v_pkg;

    localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
    localparam logic [6:0] OPC_VSTORE = 7'b0100111;
    localparam logic [6:0] OPC_OPV    = 7'b1010111;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } v_dispatch_entry_t;

    typedef enum logic [1:0] {
        V_CLASS_OTHER,
        V_CLASS_LOAD,
        V_CLASS_STORE
    } v_class_e;

    // Only memory ops matter for ordering; OP-V and config both fall into OTHER.
    function automatic v_class_e classify(input logic [31:0] instr);
        v_class_e cls;
        cls = V_CLASS_OTHER;
        if (instr[6:0] == OPC_VLOAD) begin
            cls = V_CLASS_LOAD;
        end else if (instr[6:0] == OPC_VSTORE) begin
            cls = V_CLASS_STORE;
        end
        return cls;
    endfunction

endpackage

// File: rtl/v_instr_fifo.sv
// Synchronous FIFO of dispatch entries; the head is read straight from storage.
module v_instr_fifo
    import riscv_v_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    push,
    input  v_dispatch_entry_t       push_data,
    input  logic                    pop,
    output v_dispatch_entry_t       head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    v_dispatch_entry_t mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is cleared on reset so the head outputs read zero afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/v_dispatch_ctrl.sv
// Vector instruction dispatch controller: queue, stall and load/store tracking.
// Optional same-cycle bypass of an empty queue is enabled by V_DISPATCH_BYPASS_EN.
module v_dispatch_ctrl
    import riscv_v_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        v_instr_valid_i,
    input  logic [31:0] v_instruction_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        vector_stall_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] vector_instr_o,
    output logic [31:0] rs1_o,
    output logic [31:0] rs2_o,
    input  logic        v_load_done_i,
    input  logic        v_store_done_i,
    output logic        all_v_loads_executed_o,
    output logic        all_v_stores_executed_o
);

    localparam int            CW      = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

    v_class_e                 cls;
    logic                     is_load;
    logic                     is_store;
    logic                     accept;
    logic                     bypass;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(DEPTH):0]   fifo_count;
    v_dispatch_entry_t        in_entry;
    v_dispatch_entry_t        head;
    logic [CW-1:0]            ld_cnt;
    logic [CW-1:0]            st_cnt;
    logic                     ld_inc;
    logic                     ld_dec;
    logic                     st_inc;
    logic                     st_dec;

    assign cls      = classify(v_instruction_i);
    assign is_load  = (cls == V_CLASS_LOAD);
    assign is_store = (cls == V_CLASS_STORE);

    assign in_entry.instr = v_instruction_i;
    assign in_entry.rs1   = rs1_i;
    assign in_entry.rs2   = rs2_i;

    // A pop in the same cycle does not free a slot for the offer.
    assign vector_stall_o = v_instr_valid_i &&
                            (fifo_full ||
                             (is_load  && (ld_cnt == CNT_MAX)) ||
                             (is_store && (st_cnt == CNT_MAX)));
    assign accept = v_instr_valid_i && !vector_stall_o;

`ifdef V_DISPATCH_BYPASS_EN
    assign bypass         = accept && fifo_empty && instr_ready_i;
    assign instr_valid_o  = (fifo_count != '0) || bypass;
    assign vector_instr_o = bypass ? v_instruction_i : head.instr;
    assign rs1_o          = bypass ? rs1_i : head.rs1;
    assign rs2_o          = bypass ? rs2_i : head.rs2;
`else
    assign bypass         = 1'b0;
    assign instr_valid_o  = (fifo_count != '0);
    assign vector_instr_o = head.instr;
    assign rs1_o          = head.rs1;
    assign rs2_o          = head.rs2;
`endif

    assign push = accept && !bypass;
    assign pop  = !fifo_empty && instr_ready_i;

    v_instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (in_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Counting starts at accept, so queued memory ops already block the scalar side.
    assign ld_inc = accept && is_load;
    assign st_inc = accept && is_store;
    assign ld_dec = v_load_done_i  && (ld_cnt != '0);
    assign st_dec = v_store_done_i && (st_cnt != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else begin
            if (ld_inc && !ld_dec) begin
                ld_cnt <= ld_cnt + CW'(1);
            end else if (!ld_inc && ld_dec) begin
                ld_cnt <= ld_cnt - CW'(1);
            end
            if (st_inc && !st_dec) begin
                st_cnt <= st_cnt + CW'(1);
            end else if (!st_inc && st_dec) begin
                st_cnt <= st_cnt - CW'(1);
            end
        end
    end

    assign all_v_loads_executed_o  = (ld_cnt == '0);
    assign all_v_stores_executed_o = (st_cnt == '0);

endmodule

// File: tb/tb_v_dispatch_ctrl.sv
// Self-checking bench for v_dispatch_ctrl; a monitor pops a scoreboard of expected dispatches.
module tb_v_dispatch_ctrl;
    import riscv_v_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        v_instr_valid_i;
    logic [31:0] v_instruction_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        vector_stall_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] vector_instr_o;
    logic [31:0] rs1_o;
    logic [31:0] rs2_o;
    logic        v_load_done_i;
    logic        v_store_done_i;
    logic        all_v_loads_executed_o;
    logic        all_v_stores_executed_o;

    v_dispatch_entry_t sb[$];
    v_dispatch_entry_t exp_e;
    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] OP_BASE = 32'h0000_0057;
    localparam logic [31:0] LD_BASE = 32'h0000_0007;
    localparam logic [31:0] ST_BASE = 32'h0000_0027;

    always #5 clk = ~clk;

    v_dispatch_ctrl #(
        .DEPTH   (4),
        .MAX_OUT (15)
    ) dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .v_instr_valid_i         (v_instr_valid_i),
        .v_instruction_i         (v_instruction_i),
        .rs1_i                   (rs1_i),
        .rs2_i                   (rs2_i),
        .vector_stall_o          (vector_stall_o),
        .instr_valid_o           (instr_valid_o),
        .instr_ready_i           (instr_ready_i),
        .vector_instr_o          (vector_instr_o),
        .rs1_o                   (rs1_o),
        .rs2_o                   (rs2_o),
        .v_load_done_i           (v_load_done_i),
        .v_store_done_i          (v_store_done_i),
        .all_v_loads_executed_o  (all_v_loads_executed_o),
        .all_v_stores_executed_o (all_v_stores_executed_o)
    );

    // Every handshake must match the oldest accepted entry.
    always @(negedge clk) begin
        if (rstn && instr_valid_o && instr_ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL dispatch_unexpected got instr=%h expected no dispatch", vector_instr_o);
            end else begin
                exp_e = sb.pop_front();
                if ({vector_instr_o, rs1_o, rs2_o} !== exp_e) begin
                    failures++;
                    $display("[TB] FAIL dispatch_order got %h/%h/%h expected %h/%h/%h",
                             vector_instr_o, rs1_o, rs2_o, exp_e.instr, exp_e.rs1, exp_e.rs2);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic valid, input logic [31:0] instr, input logic [31:0] r1,
                          input logic [31:0] r2, input logic ready, input logic ld_done,
                          input logic st_done, input bit exp_accept);
        v_dispatch_entry_t e;
        v_instr_valid_i = valid;
        v_instruction_i = instr;
        rs1_i           = r1;
        rs2_i           = r2;
        instr_ready_i   = ready;
        v_load_done_i   = ld_done;
        v_store_done_i  = st_done;
        if (valid && exp_accept) begin
            e.instr = instr;
            e.rs1   = r1;
            e.rs2   = r2;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        while (sb.size() != 0 && c < 20) begin
            @(negedge clk);
            tick();
            c++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (vector_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b exp=0", vector_stall_o); end
        checks++;
        if (instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", instr_valid_o); end
        checks++;
        if (all_v_loads_executed_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_loads got=%b exp=1", all_v_loads_executed_o); end
        checks++;
        if (all_v_stores_executed_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_stores got=%b exp=1", all_v_stores_executed_o); end
        checks++;
        if (vector_instr_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got=%h exp=0", vector_instr_o); end
        tick();
    endtask

    task automatic test_fill_drain();
        logic [31:0] i5;
        i5 = OP_BASE + (32'd4 << 7);
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, OP_BASE + (32'(k) << 7), 32'h100 + 32'(k), 32'h200 + 32'(k), 1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            checks++;
            if (vector_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL fill_stall k=%0d got=%b exp=0", k, vector_stall_o); end
            tick();
        end
        set_in(1'b1, i5, 32'h104, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (vector_stall_o !== 1'b1) begin failures++; $display("[TB] FAIL full_stall got=%b exp=1", vector_stall_o); end
        checks++;
        if (instr_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL full_valid got=%b exp=1", instr_valid_o); end
        checks++;
        if (vector_instr_o !== OP_BASE) begin failures++; $display("[TB] FAIL full_head got=%h exp=%h", vector_instr_o, OP_BASE); end
        tick();
        set_in(1'b1, i5, 32'h104, 32'h204, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (vector_stall_o !== 1'b1) begin failures++; $display("[TB] FAIL full_pop_stall got=%b exp=1", vector_stall_o); end
        tick();
        set_in(1'b1, i5, 32'h104, 32'h204, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (vector_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL fifth_accept got=%b exp=0", vector_stall_o); end
        tick();
        drain();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin failures++; $display("[TB] FAIL drain_left got=%0d exp=0", sb.size()); end
        checks++;
        if (instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL drain_valid got=%b exp=0", instr_valid_o); end
        tick();
    endtask

    task automatic test_load_tracking();
        set_in(1'b1, LD_BASE, 32'h1000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (all_v_loads_executed_o !== 1'b1) begin failures++; $display("[TB] FAIL ld_same_cycle got=%b exp=1", all_v_loads_executed_o); end
        tick();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (all_v_loads_executed_o !== 1'b0) begin failures++; $display("[TB] FAIL ld_outstanding got=%b exp=0", all_v_loads_executed_o); end
        checks++;
        if (all_v_stores_executed_o !== 1'b1) begin failures++; $display("[TB] FAIL ld_stores_flag got=%b exp=1", all_v_stores_executed_o); end
        tick();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (all_v_loads_executed_o !== 1'b0) begin failures++; $display("[TB] FAIL ld_done_cycle got=%b exp=0", all_v_loads_executed_o); end
        tick();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (all_v_loads_executed_o !== 1'b1) begin failures++; $display("[TB] FAIL ld_released got=%b exp=1", all_v_loads_executed_o); end
        tick();
        drain();
    endtask

    task automatic test_counter_saturation();
        logic [31:0] s16;
        s16 = ST_BASE + (32'd15 << 7);
        for (int k = 0; k < 15; k++) begin
            set_in(1'b1, ST_BASE + (32'(k) << 7), 32'h2000 + 32'(k), 32'h3000 + 32'(k), 1'b1, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            checks++;
            if (vector_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL st_accept k=%0d got=%b exp=0", k, vector_stall_o); end
            tick();
        end
        set_in(1'b1, s16, 32'h200f, 32'h300f, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (vector_stall_o !== 1'b1) begin failures++; $display("[TB] FAIL st_saturated got=%b exp=1", vector_stall_o); end
        checks++;
        if (all_v_stores_executed_o !== 1'b0) begin failures++; $display("[TB] FAIL st_flag got=%b exp=0", all_v_stores_executed_o); end
        tick();
        set_in(1'b1, OP_BASE + (32'd9 << 7), 32'h4000, 32'h5000, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (vector_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL opv_while_sat got=%b exp=0", vector_stall_o); end
        tick();
        set_in(1'b1, s16, 32'h200f, 32'h300f, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (vector_stall_o !== 1'b1) begin failures++; $display("[TB] FAIL st_done_cycle got=%b exp=1", vector_stall_o); end
        tick();
        set_in(1'b1, s16, 32'h200f, 32'h300f, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (vector_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL st_released got=%b exp=0", vector_stall_o); end
        tick();
        drain();
        for (int k = 0; k < 14; k++) begin
            set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (all_v_stores_executed_o !== 1'b0) begin failures++; $display("[TB] FAIL st_one_left got=%b exp=0", all_v_stores_executed_o); end
        tick();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (all_v_stores_executed_o !== 1'b1) begin failures++; $display("[TB] FAIL st_all_done got=%b exp=1", all_v_stores_executed_o); end
        tick();
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, LD_BASE + (32'(k) << 7), 32'h6000 + 32'(k), 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
            tick();
        end
        set_in(1'b1, LD_BASE + (32'd3 << 7), 32'h6003, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (vector_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL sim_ld_accept got=%b exp=0", vector_stall_o); end
        tick();
        for (int k = 0; k < 2; k++) begin
            set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (all_v_loads_executed_o !== 1'b0) begin failures++; $display("[TB] FAIL sim_ld_cnt3 got=%b exp=0", all_v_loads_executed_o); end
        tick();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (all_v_loads_executed_o !== 1'b1) begin failures++; $display("[TB] FAIL sim_ld_zero got=%b exp=1", all_v_loads_executed_o); end
        tick();
        set_in(1'b1, LD_BASE, 32'h7000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (vector_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL no_underflow_stall got=%b exp=0", vector_stall_o); end
        checks++;
        if (all_v_loads_executed_o !== 1'b1) begin failures++; $display("[TB] FAIL no_underflow_flag got=%b exp=1", all_v_loads_executed_o); end
        tick();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (all_v_loads_executed_o !== 1'b1) begin failures++; $display("[TB] FAIL ld_back_to_zero got=%b exp=1", all_v_loads_executed_o); end
        tick();
        drain();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            set_in(1'b1, OP_BASE + (32'(k + 16) << 7), 32'h8000 + 32'(k), 32'h9000 + 32'(k), 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        set_in(1'b1, OP_BASE + (32'd18 << 7), 32'h8002, 32'h9002, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (vector_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL pushpop_stall got=%b exp=0", vector_stall_o); end
        tick();
        for (int k = 0; k < 2; k++) begin
            set_in(1'b1, OP_BASE + (32'(k + 19) << 7), 32'h8003 + 32'(k), 32'h9003 + 32'(k), 1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            checks++;
            if (vector_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL refill k=%0d got=%b exp=0", k, vector_stall_o); end
            tick();
        end
        set_in(1'b1, OP_BASE + (32'd21 << 7), 32'h8005, 32'h9005, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (vector_stall_o !== 1'b1) begin failures++; $display("[TB] FAIL count2_full got=%b exp=1", vector_stall_o); end
        tick();
        drain();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin failures++; $display("[TB] FAIL b2b_left got=%0d exp=0", sb.size()); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, LD_BASE, 32'ha000, 32'hb000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b1, LD_BASE + (32'd1 << 7), 32'ha001, 32'hb001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b1, OP_BASE + (32'd30 << 7), 32'ha002, 32'hb002, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid got=%b exp=0", instr_valid_o); end
        checks++;
        if ({vector_instr_o, rs1_o, rs2_o} !== 96'h0) begin failures++; $display("[TB] FAIL rstmid_data got=%h/%h/%h exp=0", vector_instr_o, rs1_o, rs2_o); end
        checks++;
        if (all_v_loads_executed_o !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_loads got=%b exp=1", all_v_loads_executed_o); end
        checks++;
        if (vector_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_stall got=%b exp=0", vector_stall_o); end
        sb.delete();
        @(posedge clk);
        #3 rstn = 1'b1;
        tick();
        set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (instr_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_empty got=%b exp=0", instr_valid_o); end
        tick();
        set_in(1'b1, OP_BASE + (32'd31 << 7), 32'hc000, 32'hd000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drain();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin failures++; $display("[TB] FAIL rstmid_after got=%0d exp=0", sb.size()); end
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_load_tracking();
        test_counter_saturation();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
